// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
//   state_e      : loader FSM states
//   ERR_*        : err_code values reported on the top-level err_code port
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StHdr0  = 3'd0,
    StHdr1  = 3'd1,
    StCheck = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the byte source / instruction memory and the loader.
//   in_valid, in_data, in_ready : byte stream valid/ready handshake
//   wr_en, wr_addr, wr_data     : instruction memory word-write port
// slave  : loader side (consumes bytes, drives the write port)
// master : environment side (produces bytes, observes the write port)
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes little-endian into a 32-bit word.
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   clr_i        : synchronous clear, drops any partially assembled word
//   byte_valid_i : a byte is accepted this cycle
//   byte_i       : byte value
//   word_valid_o : combinational, high on the cycle the 4th byte is accepted
//   word_o       : {byte_i, b2, b1, b0}, valid while word_valid_o is high
module word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] bytes_q, bytes_d;

  always_comb begin
    idx_d        = idx_q;
    bytes_d      = bytes_q;
    word_valid_o = 1'b0;
    word_o       = {byte_i, bytes_q};
    if (clr_i) begin
      idx_d   = 2'd0;
      bytes_d = 24'd0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0: bytes_d[7:0]   = byte_i;
        2'd1: bytes_d[15:8]  = byte_i;
        2'd2: bytes_d[23:16] = byte_i;
        2'd3: word_valid_o   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q   <= 2'd0;
      bytes_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Consumes a byte stream: count (2 bytes LE), count x 32-bit LE words, XOR checksum byte.
// Each completed word is written to the instruction memory one cycle after its last byte.
// The core is held in reset until a load finishes with a matching checksum.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   bus          : byte stream handshake + instruction memory write port (slave side)
//   start        : pulse, re-arms the loader from DONE or ERROR
//   core_reset   : high while the processor must stay in reset
//   busy         : load in progress
//   done         : load finished, checksum OK
//   error        : load aborted
//   err_code     : ERR_OVF (count too large) or ERR_CSUM (checksum mismatch)
//   words_loaded : number of words written in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.slave     bus,
  input  logic             start,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [7:0]       csum_q, csum_d;
  logic [1:0]       err_q, err_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic        in_ready;
  logic        hs;
  logic        rearm;
  logic        word_valid;
  logic [31:0] word;

  assign hs    = bus.in_valid && in_ready;
  assign rearm = start && ((state_q == StDone) || (state_q == StError));

  word_assembler u_word_assembler (
    .clk_i        (clk),
    .reset_i      (reset),
    .clr_i        (rearm),
    .byte_valid_i (hs && (state_q == StData)),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StHdr0;
      count_q   <= '0;
      words_q   <= '0;
      csum_q    <= 8'd0;
      err_q     <= ERR_NONE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_BASE;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      words_q   <= words_d;
      csum_q    <= csum_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    csum_d    = csum_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StHdr0: begin
        if (hs) begin
          count_d = CNT_W'(bus.in_data);
          csum_d  = csum_q ^ bus.in_data;
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (hs) begin
          count_d = CNT_W'({bus.in_data, count_q[7:0]});
          csum_d  = csum_q ^ bus.in_data;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (32'(count_q) > MAX_WORDS) begin
          err_d   = ERR_OVF;
          state_d = StError;
        end else if (count_q == '0) begin
          state_d = StCsum;
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        if (hs) begin
          csum_d = csum_q ^ bus.in_data;
        end
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = word;
          wr_addr_d = ADDR_BASE + 32'({words_q, 2'b00});
          words_d   = words_q + CntOne;
          if (words_q == count_q - CntOne) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (hs) begin
          if (bus.in_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = ERR_CSUM;
            state_d = StError;
          end
        end
      end
      StDone, StError: begin
        if (start) begin
          state_d = StHdr0;
          count_d = '0;
          words_d = '0;
          csum_d  = 8'd0;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = StHdr0;
    endcase
  end

  // Outputs: status decoded from state, write port straight from registers
  always_comb begin
    in_ready     = 1'b0;
    done         = (state_q == StDone);
    error        = (state_q == StError);
    busy         = !((state_q == StDone) || (state_q == StError));
    core_reset   = (state_q != StDone);
    err_code     = err_q;
    words_loaded = words_q;
    unique case (state_q)
      StHdr0, StHdr1, StData, StCsum: in_ready = !reset;
      default:                        in_ready = 1'b0;
    endcase
    bus.in_ready = in_ready;
    bus.wr_en    = wr_en_q;
    bus.wr_addr  = wr_addr_q;
    bus.wr_data  = wr_data_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        core_reset, busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_BASE (32'h0000_0000),
    .MAX_WORDS (256),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .start        (start),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          hs_cyc[$];

  logic [7:0] nom_q[$];
  logic [7:0] bad_q[$];
  logic [7:0] part_q[$];
  logic [7:0] ovf_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe with the cycle it appeared in
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at #1 after a posedge; returns at #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] s[$], input bit throttle, output bit ok);
    bit bok;
    int gap;
    ok = 1'b1;
    hs_cyc.delete();
    foreach (s[i]) begin
      if (throttle) begin
        gap = $urandom_range(0, 5);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(s[i], bok);
      if (!bok) ok = 1'b0;
      hs_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
    tests++; if (bus.wr_addr !== 32'h0) begin fails++; $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); end
    tests++; if (bus.wr_data !== 32'h0) begin fails++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
    tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy); end
    tests++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rst_done_error: got %b%b want 00", done, error); end
    tests++; if (err_code !== 2'b00) begin fails++; $display("FAIL rst_err_code: got %b want 00", err_code); end
    tests++; if (words_loaded !== 16'd0) begin fails++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    bit ok;
    clear_writes();
    run_stream(nom_q, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL nom_handshake: got timeout want all bytes accepted"); end
    tests++;
    if (wq_addr.size() != 2) begin
      fails++; $display("FAIL nom_write_count: got %0d want 2", wq_addr.size());
    end else begin
      tests++; if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h0050_0093) begin fails++; $display("FAIL nom_w0: got %h@%h want 00500093@0", wq_data[0], wq_addr[0]); end
      tests++; if (wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h00A0_0113) begin fails++; $display("FAIL nom_w1: got %h@%h want 00a00113@4", wq_data[1], wq_addr[1]); end
      tests++; if (wq_cyc[0] != hs_cyc[5] || wq_cyc[1] != hs_cyc[9]) begin fails++; $display("FAIL nom_latency: got cyc %0d,%0d want %0d,%0d", wq_cyc[0], wq_cyc[1], hs_cyc[5], hs_cyc[9]); end
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL nom_done_busy: got %b%b want 10", done, busy); end
    tests++; if (core_reset !== 1'b0) begin fails++; $display("FAIL nom_core_reset: got %b want 0", core_reset); end
    tests++; if (words_loaded !== 16'd2) begin fails++; $display("FAIL nom_words: got %0d want 2", words_loaded); end
    tests++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin fails++; $display("FAIL nom_idle: got ready=%b wr_en=%b want 0 0", bus.in_ready, bus.wr_en); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_throttled();
    bit ok;
    rearm();
    clear_writes();
    run_stream(nom_q, 1'b1, ok);
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL thr_handshake: got timeout want all bytes accepted"); end
    tests++;
    if (wq_addr.size() != 2) begin
      fails++; $display("FAIL thr_write_count: got %0d want 2", wq_addr.size());
    end else begin
      tests++; if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h0050_0093) begin fails++; $display("FAIL thr_w0: got %h@%h want 00500093@0", wq_data[0], wq_addr[0]); end
      tests++; if (wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h00A0_0113) begin fails++; $display("FAIL thr_w1: got %h@%h want 00a00113@4", wq_data[1], wq_addr[1]); end
      tests++; if (wq_cyc[0] != hs_cyc[5] || wq_cyc[1] != hs_cyc[9]) begin fails++; $display("FAIL thr_latency: got cyc %0d,%0d want %0d,%0d", wq_cyc[0], wq_cyc[1], hs_cyc[5], hs_cyc[9]); end
    end
    tests++; if (done !== 1'b1 || core_reset !== 1'b0 || words_loaded !== 16'd2) begin fails++; $display("FAIL thr_final: got done=%b core_reset=%b words=%0d want 1 0 2", done, core_reset, words_loaded); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_words();
    bit ok0, ok1, ok2;
    rearm();
    clear_writes();
    send_byte(8'h00, ok0);
    // start while a load is in progress must have no effect
    rearm();
    send_byte(8'h00, ok1);
    send_byte(8'h00, ok2);
    @(negedge clk);
    tests++; if (!(ok0 && ok1 && ok2)) begin fails++; $display("FAIL zero_handshake: got timeout want all bytes accepted"); end
    tests++; if (wq_addr.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wq_addr.size()); end
    tests++; if (done !== 1'b1 || core_reset !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%b core_reset=%b want 1 0", done, core_reset); end
    tests++; if (words_loaded !== 16'd0) begin fails++; $display("FAIL zero_words: got %0d want 0", words_loaded); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    bit ok;
    rearm();
    clear_writes();
    run_stream(ovf_q, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_handshake: got timeout want both bytes accepted"); end
    tests++; if (error !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL ovf_check_cycle: got error=%b ready=%b want 0 0", error, bus.in_ready); end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++; if (error !== 1'b1 || err_code !== 2'b01) begin fails++; $display("FAIL ovf_error: got error=%b code=%b want 1 01", error, err_code); end
    tests++; if (bus.in_ready !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ovf_status: got ready=%b core_reset=%b busy=%b want 0 1 0", bus.in_ready, core_reset, busy); end
    tests++; if (wq_addr.size() != 0) begin fails++; $display("FAIL ovf_writes: got %0d want 0", wq_addr.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_csum();
    bit ok;
    rearm();
    run_stream(bad_q, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL csum_handshake: got timeout want all bytes accepted"); end
    tests++; if (error !== 1'b1 || err_code !== 2'b10) begin fails++; $display("FAIL csum_error: got error=%b code=%b want 1 10", error, err_code); end
    tests++; if (core_reset !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL csum_core: got core_reset=%b done=%b want 1 0", core_reset, done); end
    @(posedge clk);
    #1;
    rearm();
    @(negedge clk);
    tests++; if (error !== 1'b0 || err_code !== 2'b00 || bus.in_ready !== 1'b1 || core_reset !== 1'b1) begin fails++; $display("FAIL csum_rearm: got error=%b code=%b ready=%b core_reset=%b want 0 00 1 1", error, err_code, bus.in_ready, core_reset); end
    @(posedge clk);
    #1;
    clear_writes();
    run_stream(nom_q, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok || done !== 1'b1 || core_reset !== 1'b0 || words_loaded !== 16'd2) begin fails++; $display("FAIL csum_reload: got ok=%b done=%b core_reset=%b words=%0d want 1 1 0 2", ok, done, core_reset, words_loaded); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rearm();
    clear_writes();
    run_stream(part_q, 1'b0, ok);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_reset: got %b want 0", bus.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (wq_addr.size() != 0) begin fails++; $display("FAIL rmid_no_write: got %0d want 0", wq_addr.size()); end
    tests++; if (bus.in_ready !== 1'b1 || busy !== 1'b1 || words_loaded !== 16'd0 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rmid_state: got ready=%b busy=%b words=%0d done=%b error=%b want 1 1 0 0 0", bus.in_ready, busy, words_loaded, done, error); end
    @(posedge clk);
    #1;
    run_stream(nom_q, 1'b0, ok);
    @(negedge clk);
    tests++;
    if (wq_addr.size() != 2) begin
      fails++; $display("FAIL rmid_write_count: got %0d want 2", wq_addr.size());
    end else begin
      tests++; if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h0050_0093) begin fails++; $display("FAIL rmid_w0: got %h@%h want 00500093@0", wq_data[0], wq_addr[0]); end
      tests++; if (wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h00A0_0113) begin fails++; $display("FAIL rmid_w1: got %h@%h want 00a00113@4", wq_data[1], wq_addr[1]); end
    end
    tests++; if (!ok || done !== 1'b1) begin fails++; $display("FAIL rmid_done: got ok=%b done=%b want 1 1", ok, done); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    nom_q  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    bad_q  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
    part_q = '{8'h02, 8'h00, 8'h93, 8'h00};
    ovf_q  = '{8'h01, 8'h01};
    test_reset();
    test_nominal();
    test_throttled();
    test_zero_words();
    test_overflow();
    test_bad_csum();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
